// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counters/registers library.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Largest legal count value for a modulus is mod-1; anything above snaps to it.
  function automatic int unsigned clamp_mod(input int unsigned val, input int unsigned mod);
    return (val >= mod) ? mod - 1 : val;
  endfunction

endpackage

// File: rtl/param_updown_mod_counter_if.sv
// Control and status bundle of the up/down modulo counter.
interface param_updown_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (output en, up_dn, load, load_val, input q, tc, ovf);
  modport slave  (input en, up_dn, load, load_val, output q, tc, ovf);
endinterface

// File: rtl/mod_counter_next.sv
// Combinational next-count logic: step, wrap/saturate at the bounds, terminal detect.
module mod_counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MOD      = 16,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up_dn,
  output logic [WIDTH-1:0] next_q,
  output logic             wrap_evt,
  output logic             at_term
);

  // One extra bit keeps MOD-1 representable and makes q > MAX_Q a real test.
  localparam logic [WIDTH:0] MAX_Q = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH:0] ONE   = (WIDTH+1)'(1);

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] step_ext;

  assign q_ext = {1'b0, q};

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    next_q   = q;
    wrap_evt = 1'b0;
    at_term  = 1'b0;
    step_ext = '0;

    if (up_dn == DIR_UP) begin
      at_term  = (q_ext == MAX_Q);
      step_ext = q_ext + ONE;
    end else begin
      at_term  = (q_ext == '0);
      step_ext = q_ext - ONE;
    end

    if (q_ext > MAX_Q) begin
      next_q = '0;
    end else if (at_term) begin
      if (SATURATE == MODE_SAT) begin
        next_q = q;
      end else begin
        next_q   = (up_dn == DIR_UP) ? '0 : MAX_Q[WIDTH-1:0];
        wrap_evt = 1'b1;
      end
    end else begin
      next_q = step_ext[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/param_updown_mod_counter.sv
// Parametrised up/down modulo-N counter with load, enable, wrap/saturate,
// combinational terminal count and registered wrap pulse.
module param_updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MOD      = 16,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic                         clk,
  input  logic                         reset,
  param_updown_mod_counter_if.slave    bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] next_q;
  logic             wrap_evt;
  logic             at_term;

  mod_counter_next #(
    .WIDTH    (WIDTH),
    .MOD      (MOD),
    .SATURATE (SATURATE)
  ) u_next (
    .q        (q_q),
    .up_dn    (bus.up_dn),
    .next_q   (next_q),
    .wrap_evt (wrap_evt),
    .at_term  (at_term)
  );

  // Load beats count; a load edge always clears the wrap pulse.
  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    if (bus.load) begin
      q_d = WIDTH'(clamp_mod(32'(bus.load_val), MOD));
    end else if (bus.en) begin
      q_d   = next_q;
      ovf_d = wrap_evt;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  // NOTE: reset is synchronous here; it is just the highest-priority branch on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.ovf = ovf_q;
  assign bus.tc  = bus.en & at_term;

endmodule
